or1k_wb_bus_arbiter: RTL and testbench
======================================

Name: or1k_wb_bus_arbiter

Overview:
Two-master to one-slave Wishbone B3 arbiter. It shares a single system bus port between the core's instruction (iwb) and data (dwb) Wishbone masters. The block sits between the processing unit's iwb/dwb interfaces and the interconnect. It adds round-robin or fixed-priority arbitration, whole-cycle and burst locking, and a response watchdog.

Parameters:
TIMEOUT_CYCLES, 255, cycles without ack/err/rty before the arbiter synthesizes err; 0 disables the watchdog.
DATA_PRIORITY, 0, 0 = round-robin on ties; 1 = dwb always wins ties.

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
iwb_adr_i, iwb_dat_i  input  32  instruction master address, write data
iwb_sel_i  input  4  instruction master byte selects
iwb_we_i, iwb_cyc_i, iwb_stb_i  input  1  instruction master control
iwb_cti_i  input  3  instruction master cycle type
iwb_bte_i  input  2  instruction master burst type
iwb_dat_o  output  32  instruction master read data
iwb_ack_o, iwb_err_o, iwb_rty_o  output  1  instruction master terminations
dwb_*  same set, same widths, for the data master
m_adr_o, m_dat_o  output  32  bus address, write data
m_sel_o  output  4  bus byte selects
m_we_o, m_cyc_o, m_stb_o  output  1  bus control
m_cti_o  output  3  bus cycle type
m_bte_o  output  2  bus burst type
m_dat_i  input  32  bus read data
m_ack_i, m_err_i, m_rty_i  input  1  bus terminations
grant_o  output  2  one-hot current owner {dwb, iwb}; 00 = idle
timeout_o  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset (rst_ni=0 at a clk_i edge):
  - state=IDLE, grant_o=00, last_grant=IWB (so dwb wins the first tie), watchdog count=0.
  - All m_* outputs are 0. All iwb/dwb ack/err/rty are 0, timeout_o=0.
  - Reset mid-transfer abandons the cycle: m_cyc_o is 0 from the next edge, and no termination is forwarded.
- States: IDLE, GNT_I, GNT_D. The state register is the only arbitration state; the m_* outputs are a combinational mux of the granted master's signals.
- In IDLE, a master requests when cyc_i&stb_i=1. m_* outputs and all terminations are 0.
  - Only one master requesting: grant it next cycle.
  - Both requesting, DATA_PRIORITY=1: GNT_D.
  - Both requesting, DATA_PRIORITY=0: grant the master that is not last_grant.
  - last_grant updates on entry to any GNT state.
- Latency: a request seen in IDLE at edge N drives m_cyc_o/m_stb_o during cycle N+1.
- In GNT_x:
  - m_* follows master x combinationally.
  - m_ack_i/m_err_i/m_rty_i route to master x only; the other master's terminations are held 0.
  - iwb_dat_o and dwb_dat_o both equal m_dat_i.
- Lock: the grant is held while master x keeps cyc_i=1, including across stb_i gaps and whole bursts (cti 010, ending with 111). There is no preemption.
- Release: when master x drops cyc_i, m_cyc_o is 0 that cycle. Next state:
  - the other master is requesting: go directly to its GNT state (no idle bubble);
  - otherwise: IDLE.
  - x re-requesting in the cycle after release goes through normal arbitration.
- Watchdog (TIMEOUT_CYCLES>0):
  - count increments each cycle with m_cyc_o&m_stb_o=1 and no m_ack_i/m_err_i/m_rty_i.
  - count clears on any termination, on a state change, or when stb drops.
  - When count==TIMEOUT_CYCLES-1 and no termination arrives that cycle:
    - assert x_err_o and timeout_o for exactly one cycle;
    - force m_stb_o=0 that cycle;
    - clear count.
  - A real termination in the same cycle wins: it is forwarded and no err is produced.
- grant_o: GNT_I=01, GNT_D=10, IDLE=00, registered with the state.
- Terminations are never generated while m_cyc_o=0, except the watchdog err described above.

Decomposition:
- Shared package or1k_wb_pkg holds:
  - the arb_state_t enum (IDLE, GNT_I, GNT_D);
  - CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111;
  - BTE_LINEAR=2'b00;
  - GRANT_IWB=2'b01, GRANT_DWB=2'b10.
- One sub-module, or1k_wb_watchdog (parameter TIMEOUT_CYCLES; inputs active, term, clear; output fire), holding the counter.

Test Plan:
- Reset with both masters requesting, rst_ni=0 for 3 cycles -> all m_* and terminations 0 and grant_o=00; after release, grant_o=10 one cycle later.
- Round-robin: both masters issue continuous single reads (each drops cyc after ack, slave acks 1 cycle after stb) -> grant_o alternates 10, 01, 10, 01 with no 00 cycles between grants.
- Burst lock: iwb issues a 4-beat CTI_INCR burst (last beat CTI_EOB) while dwb requests on beat 1 -> m_adr_o follows iwb for all 4 acks; dwb is granted the cycle after iwb_cyc_i drops; dwb_ack_o=0 throughout the burst.
- Fixed priority: DATA_PRIORITY=1, both requesting in IDLE after an iwb grant -> GNT_D selected.
- Watchdog: TIMEOUT_CYCLES=8, slave never acks a dwb write -> after 8 cycles of stb: dwb_err_o=1 and timeout_o=1 for exactly one cycle, m_stb_o=0 that cycle, iwb_err_o stays 0.
- Watchdog collision: m_ack_i arrives on the 8th cycle -> dwb_ack_o=1, dwb_err_o=0, timeout_o=0.

Source files
------------

// File: rtl/or1k_wb_pkg.sv
// Shared definitions for the OR1K Wishbone bus arbiter slice.
//
// Contents:
//   arb_state_t  - arbiter FSM state. The encoding is the one-hot grant vector
//                  {dwb, iwb}, so the state register doubles as grant_o.
//   CTI_*/BTE_*  - Wishbone B3 cycle-type / burst-type codes.
//   GRANT_*      - one-hot owner codes reported on grant_o.
package or1k_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam logic [1:0] GRANT_IWB   = 2'b01;
    localparam logic [1:0] GRANT_DWB   = 2'b10;

endpackage

// File: rtl/or1k_wb_watchdog.sv
// Response watchdog for the Wishbone arbiter.
//
// Counts consecutive cycles in which a strobe is outstanding without any
// termination. fire_o is a combinational one-cycle pulse raised in the cycle
// that would be the TIMEOUT_CYCLES-th unanswered strobe cycle.
//
// Ports:
//   clk_i, rst_ni - clock, synchronous active-low reset
//   active_i      - m_cyc & m_stb (strobe before any watchdog masking)
//   term_i        - any of ack/err/rty from the slave this cycle
//   clear_i       - arbitration state is changing this cycle
//   fire_o        - watchdog expiry pulse
// TIMEOUT_CYCLES = 0 disables the watchdog (fire_o tied low).
module or1k_wb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic term_i,
    input  logic clear_i,
    output logic fire_o
);

    localparam int unsigned CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CW-1:0] count_q, count_d;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign fire_o = 1'b0;
        end else begin : g_on
            // A real termination in the same cycle always wins over expiry.
            assign fire_o = active_i & ~term_i & (count_q == CW'(LIMIT));
        end
    endgenerate

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear_i || !active_i || term_i || fire_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/or1k_wb_bus_arbiter.sv
// Two-master (iwb, dwb) to one-slave Wishbone B3 arbiter.
//
// The granted master owns the bus for as long as it holds cyc (stb gaps and
// whole bursts included); there is no preemption. On release the other master
// is granted directly if it is requesting, otherwise the arbiter idles. Ties in
// IDLE go round-robin (DATA_PRIORITY=0) or to dwb (DATA_PRIORITY=1).
//
// Ports:
//   clk_i, rst_ni            - clock, synchronous active-low reset
//   iwb_*_i / iwb_*_o        - instruction master request / response
//   dwb_*_i / dwb_*_o        - data master request / response
//   m_*_o / m_*_i            - shared bus towards the interconnect
//   grant_o                  - one-hot owner {dwb, iwb}, 00 when idle
//   timeout_o                - one-cycle pulse when the watchdog fires
module or1k_wb_bus_arbiter
    import or1k_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned DATA_PRIORITY  = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] iwb_adr_i,
    input  logic [31:0] iwb_dat_i,
    input  logic [3:0]  iwb_sel_i,
    input  logic        iwb_we_i,
    input  logic        iwb_cyc_i,
    input  logic        iwb_stb_i,
    input  logic [2:0]  iwb_cti_i,
    input  logic [1:0]  iwb_bte_i,
    output logic [31:0] iwb_dat_o,
    output logic        iwb_ack_o,
    output logic        iwb_err_o,
    output logic        iwb_rty_o,
    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_we_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    input  logic [2:0]  dwb_cti_i,
    input  logic [1:0]  dwb_bte_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        dwb_err_o,
    output logic        dwb_rty_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic [2:0]  m_cti_o,
    output logic [1:0]  m_bte_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    input  logic        m_rty_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    arb_state_t state_q, state_d;
    logic [1:0] last_grant_q, last_grant_d;

    logic i_req, d_req, d_wins_tie;
    logic stb_raw, own_i, own_d;
    logic wd_active, wd_term, wd_clear, wd_fire;

    assign i_req      = iwb_cyc_i & iwb_stb_i;
    assign d_req      = dwb_cyc_i & dwb_stb_i;
    assign d_wins_tie = (DATA_PRIORITY != 0) || (last_grant_q == GRANT_IWB);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IWB;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = d_wins_tie ? GNT_D : GNT_I;
                end else if (i_req) begin
                    state_d = GNT_I;
                end else if (d_req) begin
                    state_d = GNT_D;
                end
            end
            // Release hands over directly to a waiting master, no idle bubble.
            GNT_I: if (!iwb_cyc_i) state_d = d_req ? GNT_D : IDLE;
            GNT_D: if (!dwb_cyc_i) state_d = i_req ? GNT_I : IDLE;
            default: state_d = IDLE;
        endcase

        last_grant_d = last_grant_q;
        if (state_d != state_q && state_d != IDLE) begin
            last_grant_d = (state_d == GNT_D) ? GRANT_DWB : GRANT_IWB;
        end
    end

    // Output logic: combinational mux of the granted master
    always_comb begin
        m_adr_o = '0;
        m_dat_o = '0;
        m_sel_o = '0;
        m_we_o  = 1'b0;
        m_cyc_o = 1'b0;
        stb_raw = 1'b0;
        m_cti_o = '0;
        m_bte_o = '0;
        case (state_q)
            GNT_I: begin
                m_adr_o = iwb_adr_i;
                m_dat_o = iwb_dat_i;
                m_sel_o = iwb_sel_i;
                m_we_o  = iwb_we_i;
                m_cyc_o = iwb_cyc_i;
                stb_raw = iwb_stb_i;
                m_cti_o = iwb_cti_i;
                m_bte_o = iwb_bte_i;
            end
            GNT_D: begin
                m_adr_o = dwb_adr_i;
                m_dat_o = dwb_dat_i;
                m_sel_o = dwb_sel_i;
                m_we_o  = dwb_we_i;
                m_cyc_o = dwb_cyc_i;
                stb_raw = dwb_stb_i;
                m_cti_o = dwb_cti_i;
                m_bte_o = dwb_bte_i;
            end
            default: ;
        endcase
    end

    assign own_i = (state_q == GNT_I);
    assign own_d = (state_q == GNT_D);

    // The watchdog sees the unmasked strobe so that masking stb on expiry
    // does not feed back into the expiry decision.
    assign wd_active = m_cyc_o & stb_raw;
    assign wd_term   = m_ack_i | m_err_i | m_rty_i;
    assign wd_clear  = (state_d != state_q);

    or1k_wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .active_i(wd_active),
        .term_i  (wd_term),
        .clear_i (wd_clear),
        .fire_o  (wd_fire)
    );

    // On expiry the strobe is withdrawn and the owner sees a synthesized err.
    assign m_stb_o   = stb_raw & ~wd_fire;
    assign timeout_o = wd_fire;

    assign iwb_ack_o = own_i & m_cyc_o & m_ack_i;
    assign iwb_err_o = own_i & ((m_cyc_o & m_err_i) | wd_fire);
    assign iwb_rty_o = own_i & m_cyc_o & m_rty_i;
    assign dwb_ack_o = own_d & m_cyc_o & m_ack_i;
    assign dwb_err_o = own_d & ((m_cyc_o & m_err_i) | wd_fire);
    assign dwb_rty_o = own_d & m_cyc_o & m_rty_i;

    assign iwb_dat_o = m_dat_i;
    assign dwb_dat_o = m_dat_i;
    assign grant_o   = state_q;

endmodule

// File: tb/tb_or1k_wb_bus_arbiter.sv
// Bench for or1k_wb_bus_arbiter: a round-robin instance (index 0) and a
// data-priority instance (index 1) share the same master/slave stimulus; each
// is compared every cycle with its own behavioural owner/stall model.
module tb_or1k_wb_bus_arbiter;
    import or1k_wb_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] iwb_adr, iwb_dat, dwb_adr, dwb_dat, m_dat;
    logic [3:0]  iwb_sel, dwb_sel;
    logic        iwb_we, iwb_cyc, iwb_stb, dwb_we, dwb_cyc, dwb_stb;
    logic [2:0]  iwb_cti, dwb_cti;
    logic [1:0]  iwb_bte, dwb_bte;
    logic        m_ack, m_err, m_rty;

    logic [31:0] o_iwb_dat[2], o_dwb_dat[2], o_m_adr[2], o_m_dat[2];
    logic        o_iwb_ack[2], o_iwb_err[2], o_iwb_rty[2];
    logic        o_dwb_ack[2], o_dwb_err[2], o_dwb_rty[2];
    logic [3:0]  o_m_sel[2];
    logic        o_m_we[2], o_m_cyc[2], o_m_stb[2], o_timeout[2];
    logic [2:0]  o_m_cti[2];
    logic [1:0]  o_m_bte[2], o_grant[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        or1k_wb_bus_arbiter #(
            .TIMEOUT_CYCLES(TO),
            .DATA_PRIORITY (g)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .iwb_adr_i(iwb_adr), .iwb_dat_i(iwb_dat), .iwb_sel_i(iwb_sel),
            .iwb_we_i(iwb_we), .iwb_cyc_i(iwb_cyc), .iwb_stb_i(iwb_stb),
            .iwb_cti_i(iwb_cti), .iwb_bte_i(iwb_bte),
            .iwb_dat_o(o_iwb_dat[g]), .iwb_ack_o(o_iwb_ack[g]),
            .iwb_err_o(o_iwb_err[g]), .iwb_rty_o(o_iwb_rty[g]),
            .dwb_adr_i(dwb_adr), .dwb_dat_i(dwb_dat), .dwb_sel_i(dwb_sel),
            .dwb_we_i(dwb_we), .dwb_cyc_i(dwb_cyc), .dwb_stb_i(dwb_stb),
            .dwb_cti_i(dwb_cti), .dwb_bte_i(dwb_bte),
            .dwb_dat_o(o_dwb_dat[g]), .dwb_ack_o(o_dwb_ack[g]),
            .dwb_err_o(o_dwb_err[g]), .dwb_rty_o(o_dwb_rty[g]),
            .m_adr_o(o_m_adr[g]), .m_dat_o(o_m_dat[g]), .m_sel_o(o_m_sel[g]),
            .m_we_o(o_m_we[g]), .m_cyc_o(o_m_cyc[g]), .m_stb_o(o_m_stb[g]),
            .m_cti_o(o_m_cti[g]), .m_bte_o(o_m_bte[g]),
            .m_dat_i(m_dat), .m_ack_i(m_ack), .m_err_i(m_err), .m_rty_i(m_rty),
            .grant_o(o_grant[g]), .timeout_o(o_timeout[g])
        );
    end

    // Scoreboard counters
    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner 0 = nobody, 1 = iwb, 2 = dwb
    int own[2];
    int lastg[2];
    int stall[2];
    int dp[2] = '{0, 1};

    // What instance 0 is expected to present this cycle (drives reactive stimulus)
    logic exp_i_term, exp_d_term, exp_stb_a;
    int n_to, n_dack, n_derr, n_ierr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            string pfx;
            logic cyc_x, stb_x, term, fire;
            logic [31:0] e_adr, e_dat;
            logic [9:0] e_ctl;
            logic [2:0] e_it, e_dt;
            logic [1:0] e_gnt;
            pfx   = (k == 0) ? "rr." : "fp.";
            cyc_x = (own[k] == 1) ? iwb_cyc : (own[k] == 2) ? dwb_cyc : 1'b0;
            stb_x = (own[k] == 1) ? iwb_stb : (own[k] == 2) ? dwb_stb : 1'b0;
            term  = m_ack | m_err | m_rty;
            fire  = (own[k] != 0) && cyc_x && stb_x && !term && (stall[k] == TO - 1);
            e_gnt = (own[k] == 1) ? GRANT_IWB : (own[k] == 2) ? GRANT_DWB : 2'b00;
            e_adr = (own[k] == 1) ? iwb_adr : (own[k] == 2) ? dwb_adr : 32'h0;
            e_dat = (own[k] == 1) ? iwb_dat : (own[k] == 2) ? dwb_dat : 32'h0;
            e_ctl = (own[k] == 1) ? {iwb_we, iwb_sel, iwb_cti, iwb_bte} :
                    (own[k] == 2) ? {dwb_we, dwb_sel, dwb_cti, dwb_bte} : 10'h0;
            e_it  = (own[k] == 1) ? {cyc_x & m_ack, (cyc_x & m_err) | fire, cyc_x & m_rty} : 3'b0;
            e_dt  = (own[k] == 2) ? {cyc_x & m_ack, (cyc_x & m_err) | fire, cyc_x & m_rty} : 3'b0;

            check_eq({pfx, "grant"}, o_grant[k], e_gnt);
            check_eq({pfx, "m_cyc_stb"}, {o_m_cyc[k], o_m_stb[k]}, {cyc_x, stb_x & ~fire});
            check_eq({pfx, "m_adr"}, o_m_adr[k], e_adr);
            check_eq({pfx, "m_dat"}, o_m_dat[k], e_dat);
            check_eq({pfx, "m_ctl"}, {o_m_we[k], o_m_sel[k], o_m_cti[k], o_m_bte[k]}, e_ctl);
            check_eq({pfx, "iwb_term"}, {o_iwb_ack[k], o_iwb_err[k], o_iwb_rty[k]}, e_it);
            check_eq({pfx, "dwb_term"}, {o_dwb_ack[k], o_dwb_err[k], o_dwb_rty[k]}, e_dt);
            check_eq({pfx, "timeout"}, o_timeout[k], fire);
            check_eq({pfx, "rdata"}, {o_iwb_dat[k] ^ m_dat, o_dwb_dat[k] ^ m_dat}, 32'h0);

            if (k == 0) begin
                exp_i_term = |e_it;
                exp_d_term = |e_dt;
                exp_stb_a  = cyc_x & stb_x & ~fire;
                n_to   += int'(o_timeout[0]);
                n_dack += int'(o_dwb_ack[0]);
                n_derr += int'(o_dwb_err[0]);
                n_ierr += int'(o_iwb_err[0]);
            end
        end
    endtask

    // Advance the model across one clock edge using the inputs present at it.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic ireq, dreq, cyc_x, stb_x, active, term, fire;
            int nxt;
            if (!rst_n) begin
                own[k]   = 0;
                lastg[k] = 1;
                stall[k] = 0;
            end else begin
                ireq = iwb_cyc && iwb_stb;
                dreq = dwb_cyc && dwb_stb;
                nxt  = own[k];
                if (own[k] == 1 && !iwb_cyc) nxt = dreq ? 2 : 0;
                else if (own[k] == 2 && !dwb_cyc) nxt = ireq ? 1 : 0;
                else if (own[k] == 0) begin
                    if (ireq && dreq) nxt = (dp[k] != 0 || lastg[k] == 1) ? 2 : 1;
                    else if (ireq) nxt = 1;
                    else if (dreq) nxt = 2;
                end
                cyc_x  = (own[k] == 1) ? iwb_cyc : (own[k] == 2) ? dwb_cyc : 1'b0;
                stb_x  = (own[k] == 1) ? iwb_stb : (own[k] == 2) ? dwb_stb : 1'b0;
                active = (own[k] != 0) && cyc_x && stb_x;
                term   = m_ack | m_err | m_rty;
                fire   = active && !term && (stall[k] == TO - 1);
                stall[k] = (nxt != own[k] || !active || term || fire) ? 0 : stall[k] + 1;
                if (nxt != 0 && nxt != own[k]) lastg[k] = nxt;
                own[k] = nxt;
            end
        end
    endtask

    // Inputs for this cycle are already applied; check, then take the edge.
    task automatic cycle();
        #4;
        check_outputs();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic go_idle();
        iwb_cyc = 1'b0; iwb_stb = 1'b0; dwb_cyc = 1'b0; dwb_stb = 1'b0;
        m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0; rst_n = 1'b1;
        cycle();
        cycle();
    endtask

    function automatic logic [2:0] pick_cti();
        case ($urandom_range(0, 2))
            0:       return CTI_CLASSIC;
            1:       return CTI_INCR;
            default: return CTI_EOB;
        endcase
    endfunction

    task automatic gen_master(input logic cyc_now, input logic term_seen, output logic cyc_nx, output logic stb_nx);
        if (cyc_now && (term_seen ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 4))) begin
            cyc_nx = 1'b0; stb_nx = 1'b0;
        end else if (cyc_now) begin
            cyc_nx = 1'b1; stb_nx = ($urandom_range(0, 99) < 80);
        end else if ($urandom_range(0, 2) == 0) begin
            cyc_nx = 1'b1; stb_nx = 1'b1;
        end else begin
            cyc_nx = 1'b0; stb_nx = 1'b0;
        end
    endtask

    task automatic gen_random(input int ack_pct);
        gen_master(iwb_cyc, exp_i_term, iwb_cyc, iwb_stb);
        gen_master(dwb_cyc, exp_d_term, dwb_cyc, dwb_stb);
        iwb_adr = $urandom; iwb_dat = $urandom; iwb_sel = 4'($urandom);
        iwb_we = 1'($urandom); iwb_cti = pick_cti(); iwb_bte = 2'($urandom);
        dwb_adr = $urandom; dwb_dat = $urandom; dwb_sel = 4'($urandom);
        dwb_we = 1'($urandom); dwb_cti = pick_cti(); dwb_bte = 2'($urandom);
        m_dat = $urandom;
        m_ack = exp_stb_a && ($urandom_range(0, 99) < ack_pct);
        m_err = ($urandom_range(0, 99) < 3);
        m_rty = ($urandom_range(0, 99) < 2);
        rst_n = ($urandom_range(0, 299) != 0);
    endtask

    initial begin
        int to0, dack0, derr0, ierr0, n_idle, n_sw;
        logic [1:0] prev_g;
        n_to = 0; n_dack = 0; n_derr = 0; n_ierr = 0;
        exp_i_term = 1'b0; exp_d_term = 1'b0; exp_stb_a = 1'b0;
        own = '{0, 0}; lastg = '{1, 1}; stall = '{0, 0};
        iwb_adr = 32'h0000_1000; iwb_dat = 32'h1111_1111; iwb_sel = 4'hf; iwb_we = 1'b0;
        iwb_cti = CTI_CLASSIC; iwb_bte = BTE_LINEAR;
        dwb_adr = 32'h0000_2000; dwb_dat = 32'h2222_2222; dwb_sel = 4'hf; dwb_we = 1'b0;
        dwb_cti = CTI_CLASSIC; dwb_bte = BTE_LINEAR;
        m_dat = 32'hcafe_f00d; m_ack = 1'b0; m_err = 1'b0; m_rty = 1'b0;

        // Reset held 3 edges with both masters requesting
        rst_n = 1'b0; iwb_cyc = 1'b1; iwb_stb = 1'b1; dwb_cyc = 1'b1; dwb_stb = 1'b1;
        @(posedge clk);
        #1;
        model_step();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check_eq("rst_first_grant", o_grant[0], GRANT_DWB);
        go_idle();

        // Burst lock: iwb 4-beat incrementing burst, dwb waiting from beat 1
        iwb_cyc = 1'b1; iwb_stb = 1'b1; iwb_cti = CTI_INCR; iwb_adr = 32'h0000_1000;
        cycle();
        for (int b = 0; b < 4; b++) begin
            iwb_adr = 32'h0000_1000 + 32'(4 * b);
            iwb_cti = (b == 3) ? CTI_EOB : CTI_INCR;
            dwb_cyc = 1'b1; dwb_stb = 1'b1;
            m_ack = 1'b1;
            cycle();
            check_eq("burst_hold", o_grant[0], GRANT_IWB);
        end
        iwb_cyc = 1'b0; iwb_stb = 1'b0; iwb_cti = CTI_CLASSIC; m_ack = 1'b0;
        cycle();
        check_eq("burst_handover", o_grant[0], GRANT_DWB);
        go_idle();

        // Tie after a dwb grant: round-robin picks iwb, data-priority picks dwb
        dwb_cyc = 1'b1; dwb_stb = 1'b1; cycle();
        dwb_cyc = 1'b0; dwb_stb = 1'b0; cycle();
        iwb_cyc = 1'b1; iwb_stb = 1'b1; dwb_cyc = 1'b1; dwb_stb = 1'b1; cycle();
        check_eq("tie_rr_after_d", o_grant[0], GRANT_IWB);
        check_eq("tie_fp_after_d", o_grant[1], GRANT_DWB);
        go_idle();
        // Tie after an iwb grant: both pick dwb
        iwb_cyc = 1'b1; iwb_stb = 1'b1; cycle();
        iwb_cyc = 1'b0; iwb_stb = 1'b0; cycle();
        iwb_cyc = 1'b1; iwb_stb = 1'b1; dwb_cyc = 1'b1; dwb_stb = 1'b1; cycle();
        check_eq("tie_rr_after_i", o_grant[0], GRANT_DWB);
        check_eq("tie_fp_after_i", o_grant[1], GRANT_DWB);
        go_idle();

        // Watchdog: dwb write that the slave never answers
        dwb_cyc = 1'b1; dwb_stb = 1'b1; dwb_we = 1'b1;
        cycle();
        to0 = n_to; derr0 = n_derr; ierr0 = n_ierr;
        for (int i = 0; i < 9; i++) cycle();
        check_eq("wd_timeout_pulses", n_to - to0, 1);
        check_eq("wd_dwb_err_pulses", n_derr - derr0, 1);
        check_eq("wd_iwb_err_pulses", n_ierr - ierr0, 0);
        go_idle();

        // Watchdog collision: ack lands in the 8th strobe cycle
        dwb_cyc = 1'b1; dwb_stb = 1'b1;
        cycle();
        to0 = n_to; derr0 = n_derr; dack0 = n_dack;
        for (int i = 0; i < 7; i++) cycle();
        m_ack = 1'b1;
        cycle();
        m_ack = 1'b0; dwb_cyc = 1'b0; dwb_stb = 1'b0; dwb_we = 1'b0;
        cycle();
        check_eq("wdc_timeout_pulses", n_to - to0, 0);
        check_eq("wdc_dwb_err_pulses", n_derr - derr0, 0);
        check_eq("wdc_dwb_acks", n_dack - dack0, 1);
        go_idle();

        // Round-robin with continuous single reads, slave acks one cycle after stb
        n_idle = 0; n_sw = 0; prev_g = 2'b00;
        for (int i = 0; i < 30; i++) begin
            if (iwb_cyc && exp_i_term) begin iwb_cyc = 1'b0; iwb_stb = 1'b0; end
            else begin iwb_cyc = 1'b1; iwb_stb = 1'b1; end
            if (dwb_cyc && exp_d_term) begin dwb_cyc = 1'b0; dwb_stb = 1'b0; end
            else begin dwb_cyc = 1'b1; dwb_stb = 1'b1; end
            m_ack = exp_stb_a && !m_ack;
            cycle();
            if (o_grant[0] == 2'b00) n_idle++;
            if (prev_g != 2'b00 && o_grant[0] != prev_g) n_sw++;
            prev_g = o_grant[0];
        end
        check_eq("rr_idle_cycles", n_idle, 0);
        check_eq("rr_switches_ge8", (n_sw >= 8), 1);
        go_idle();

        // Randomized traffic: normal, starved (watchdog-heavy), mixed
        for (int i = 0; i < 1500; i++) begin gen_random(60); cycle(); end
        for (int i = 0; i < 1500; i++) begin gen_random(5);  cycle(); end
        for (int i = 0; i < 1500; i++) begin gen_random(30); cycle(); end
        go_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
